// File: rtl/issue_queue.sv
// -----------------------------------------------------------------------------
// issue_queue
//
// Collapsing, out-of-order issue queue between rename/dispatch and
// register-read/execute. Entry 0 is always the oldest. Valid entries are
// contiguous from index 0 to count-1, so validity is derived from the
// occupancy count. Each cycle the lowest-index (oldest) ready entry is
// presented for issue. A popped entry is squeezed out by shifting every
// younger entry down one slot.
//
// Ports:
//   clk, sync_rst_n      clock (rising edge), synchronous active-low reset
//   clk_en               global enable; all state holds while low
//   flush                discard every entry at the edge
//   disp_*               dispatch channel (valid/ready handshake)
//   wake_valid/addr      WAKEUP_PORTS physical-tag wakeup broadcasts
//   iss_*                issue channel (valid/ready handshake)
//
// Optional feature (macro ISSUE_QUEUE_OCCUPANCY_EN):
//   iq_count             registered occupancy count
//   iq_almost_full       registered flag, count >= ENTRIES-2
// -----------------------------------------------------------------------------
module issue_queue #(
  parameter int ENTRIES         = 16,
  parameter int OPCODE_WIDTH    = 7,
  parameter int PHYS_COUNT      = 128,
  parameter int PHYS_ADDR_WIDTH = $clog2(PHYS_COUNT),
  parameter int WAKEUP_PORTS    = 2,
  parameter int CNT_WIDTH       = $clog2(ENTRIES + 1)
) (
  input  logic                                          clk,
  input  logic                                          sync_rst_n,
  input  logic                                          clk_en,
  input  logic                                          flush,
  input  logic                                          disp_valid,
  output logic                                          disp_ready,
  input  logic [OPCODE_WIDTH-1:0]                       disp_opcode,
  input  logic [PHYS_ADDR_WIDTH-1:0]                    disp_dest_addr,
  input  logic [1:0][PHYS_ADDR_WIDTH-1:0]               disp_src_addr,
  input  logic [1:0]                                    disp_src_used,
  input  logic [1:0]                                    disp_src_rdy,
  input  logic [WAKEUP_PORTS-1:0]                       wake_valid,
  input  logic [WAKEUP_PORTS-1:0][PHYS_ADDR_WIDTH-1:0]  wake_addr,
  output logic                                          iss_valid,
  input  logic                                          iss_ready,
  output logic [OPCODE_WIDTH-1:0]                       iss_opcode,
  output logic [PHYS_ADDR_WIDTH-1:0]                    iss_dest_addr,
  output logic [1:0][PHYS_ADDR_WIDTH-1:0]               iss_src_addr,
  output logic [1:0]                                    iss_src_used
`ifdef ISSUE_QUEUE_OCCUPANCY_EN
  ,
  output logic [CNT_WIDTH-1:0]                          iq_count,
  output logic                                          iq_almost_full
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0]         opcode;
    logic [PHYS_ADDR_WIDTH-1:0]      dest;
    logic [1:0][PHYS_ADDR_WIDTH-1:0] src_addr;
    logic [1:0]                      src_used;
    logic [1:0]                      src_rdy;
  } entry_t;

  entry_t               ent_q [ENTRIES];
  entry_t               ent_d [ENTRIES];
  entry_t               woke  [ENTRIES];
  entry_t               new_ent;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] wr_idx;
  logic [ENTRIES-1:0]   ent_vld;
  logic [ENTRIES-1:0]   ent_rdy;
  logic [IDX_W-1:0]     sel_idx;
  logic                 any_rdy;
  logic                 pop;
  logic                 push;

  // True when any valid wakeup port broadcasts this tag.
  function automatic logic tag_woken(
    input logic [PHYS_ADDR_WIDTH-1:0]                   tag,
    input logic [WAKEUP_PORTS-1:0]                      wv,
    input logic [WAKEUP_PORTS-1:0][PHYS_ADDR_WIDTH-1:0] wa
  );
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WAKEUP_PORTS; p++) begin
      if (wv[p] && (wa[p] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // An unused source never blocks issue, regardless of its ready bit.
  function automatic logic entry_ready(input entry_t e);
    return (!e.src_used[0] || e.src_rdy[0]) && (!e.src_used[1] || e.src_rdy[1]);
  endfunction

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ent_vld[i] = (CNT_WIDTH'(i) < count_q);
      ent_rdy[i] = ent_vld[i] && entry_ready(ent_q[i]);
    end
  end

  // Oldest-first select: scanning down from the top leaves the lowest
  // ready index in sel_idx.
  always_comb begin
    any_rdy = 1'b0;
    sel_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ent_rdy[i]) begin
        any_rdy = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  assign iss_valid  = sync_rst_n && clk_en && any_rdy;
  // Deliberately independent of iss_ready: no combinational path from execute.
  assign disp_ready = sync_rst_n && clk_en && (count_q < CNT_WIDTH'(ENTRIES)) && !flush;
  assign pop        = iss_valid && iss_ready && !flush;
  assign push       = disp_valid && disp_ready;

  always_comb begin
    iss_opcode    = '0;
    iss_dest_addr = '0;
    iss_src_addr  = '0;
    iss_src_used  = '0;
    if (iss_valid) begin
      iss_opcode    = ent_q[sel_idx].opcode;
      iss_dest_addr = ent_q[sel_idx].dest;
      iss_src_addr  = ent_q[sel_idx].src_addr;
      iss_src_used  = ent_q[sel_idx].src_used;
    end
  end

  always_comb begin
    // Incoming entry; a same-cycle wakeup of its tag is captured directly.
    new_ent.opcode   = disp_opcode;
    new_ent.dest     = disp_dest_addr;
    new_ent.src_addr = disp_src_addr;
    new_ent.src_used = disp_src_used;
    for (int s = 0; s < 2; s++) begin
      new_ent.src_rdy[s] = disp_src_rdy[s] |
                           tag_woken(disp_src_addr[s], wake_valid, wake_addr);
    end

    // Snoop wakeups into every valid, used source.
    for (int i = 0; i < ENTRIES; i++) begin
      woke[i] = ent_q[i];
      for (int s = 0; s < 2; s++) begin
        if (ent_vld[i] && ent_q[i].src_used[s] &&
            tag_woken(ent_q[i].src_addr[s], wake_valid, wake_addr)) begin
          woke[i].src_rdy[s] = 1'b1;
        end
      end
    end

    // Collapse: everything above the popped slot moves down one.
    for (int i = 0; i < ENTRIES; i++) begin
      ent_d[i] = woke[i];
    end
    if (pop) begin
      for (int i = 0; i < ENTRIES - 1; i++) begin
        if (IDX_W'(i) >= sel_idx) ent_d[i] = woke[i + 1];
      end
    end

    // New entry lands just above the youngest survivor.
    wr_idx = count_q - CNT_WIDTH'(pop);
    for (int i = 0; i < ENTRIES; i++) begin
      if (push && (CNT_WIDTH'(i) == wr_idx)) ent_d[i] = new_ent;
    end

    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    end
  end

  // Control state: occupancy count, cleared by reset.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      count_q <= '0;
    end else if (clk_en) begin
      count_q <= count_d;
    end
  end

  // Payload storage: validity comes from count_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

`ifdef ISSUE_QUEUE_OCCUPANCY_EN
  logic almost_full_q;

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      almost_full_q <= 1'b0;
    end else if (clk_en) begin
      almost_full_q <= (int'(count_d) >= ENTRIES - 2);
    end
  end

  assign iq_count       = count_q;
  assign iq_almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_issue_queue.sv
module tb_issue_queue;
  localparam int ENT = 16;
  localparam int OW  = 7;
  localparam int AW  = 7;
  localparam int WP  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  sync_rst_n, clk_en, flush, disp_valid, disp_ready;
  logic [OW-1:0]         disp_opcode;
  logic [AW-1:0]         disp_dest_addr;
  logic [1:0][AW-1:0]    disp_src_addr;
  logic [1:0]            disp_src_used, disp_src_rdy;
  logic [WP-1:0]         wake_valid;
  logic [WP-1:0][AW-1:0] wake_addr;
  logic                  iss_valid, iss_ready;
  logic [OW-1:0]         iss_opcode;
  logic [AW-1:0]         iss_dest_addr;
  logic [1:0][AW-1:0]    iss_src_addr;
  logic [1:0]            iss_src_used;

  issue_queue #(.ENTRIES(ENT)) dut (
    .clk(clk), .sync_rst_n(sync_rst_n), .clk_en(clk_en), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_opcode(disp_opcode),
    .disp_dest_addr(disp_dest_addr), .disp_src_addr(disp_src_addr),
    .disp_src_used(disp_src_used), .disp_src_rdy(disp_src_rdy),
    .wake_valid(wake_valid), .wake_addr(wake_addr),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_opcode(iss_opcode),
    .iss_dest_addr(iss_dest_addr), .iss_src_addr(iss_src_addr),
    .iss_src_used(iss_src_used)
  );

  // Reference model: an age-ordered list of instructions.
  typedef struct packed {
    logic [OW-1:0]      op;
    logic [AW-1:0]      dest;
    logic [1:0][AW-1:0] sa;
    logic [1:0]         used;
    logic [1:0]         rdy;
  } m_ent_t;

  m_ent_t      mq[$];
  int          checks = 0;
  int          errors = 0;
  logic        exp_iv, exp_dr;
  int          exp_idx;
  logic [31:0] exp_vec, obs_vec;

  function automatic logic m_ready(input m_ent_t e);
    return (!e.used[0] || e.rdy[0]) && (!e.used[1] || e.rdy[1]);
  endfunction

  function automatic logic m_wake_hit(input logic [AW-1:0] tag);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WP; p++) if (wake_valid[p] && wake_addr[p] == tag) hit = 1'b1;
    return hit;
  endfunction

  task automatic model_eval();
    exp_idx = -1;
    for (int k = 0; k < mq.size(); k++) if (exp_idx < 0 && m_ready(mq[k])) exp_idx = k;
    exp_iv  = sync_rst_n && clk_en && (exp_idx >= 0);
    exp_dr  = sync_rst_n && clk_en && (mq.size() < ENT) && !flush;
    exp_vec = {exp_iv, exp_dr, 30'b0};
    if (exp_iv) exp_vec[29:0] = {mq[exp_idx].op, mq[exp_idx].dest, mq[exp_idx].sa, mq[exp_idx].used};
    obs_vec = {iss_valid, disp_ready, iss_opcode, iss_dest_addr, iss_src_addr, iss_src_used};
  endtask

  task automatic model_tick();
    m_ent_t n, t;
    logic   do_pop, do_push;
    if (!sync_rst_n) begin
      mq.delete();
    end else if (clk_en) begin
      if (flush) begin
        mq.delete();
      end else begin
        do_pop  = exp_iv && iss_ready;
        do_push = disp_valid && exp_dr;
        n.op = disp_opcode; n.dest = disp_dest_addr; n.sa = disp_src_addr; n.used = disp_src_used;
        for (int s = 0; s < 2; s++) n.rdy[s] = disp_src_rdy[s] | m_wake_hit(disp_src_addr[s]);
        for (int k = 0; k < mq.size(); k++) begin
          t = mq[k];
          for (int s = 0; s < 2; s++) if (t.used[s] && m_wake_hit(t.sa[s])) t.rdy[s] = 1'b1;
          mq[k] = t;
        end
        if (do_pop) mq.delete(exp_idx);
        if (do_push) mq.push_back(n);
      end
    end
  endtask

  task automatic advance();
    model_eval();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic idle();
    clk_en = 1'b1; flush = 1'b0; disp_valid = 1'b0; wake_valid = '0; wake_addr = '0;
    disp_opcode = '0; disp_dest_addr = '0; disp_src_addr = '0; disp_src_used = '0; disp_src_rdy = '0;
  endtask

  task automatic set_disp(input logic [OW-1:0] op, input logic [AW-1:0] a0,
                          input logic [AW-1:0] a1, input logic [1:0] used, input logic [1:0] rdy);
    disp_valid = 1'b1; disp_opcode = op; disp_dest_addr = op ^ 7'h55;
    disp_src_addr[0] = a0; disp_src_addr[1] = a1; disp_src_used = used; disp_src_rdy = rdy;
  endtask

  task automatic clear_q();
    idle(); flush = 1'b1; #1; advance(); idle();
  endtask

  task automatic test_reset();
    sync_rst_n = 1'b0; idle(); iss_ready = 1'b1; set_disp(7'h11, 0, 0, 2'b00, 2'b00);
    for (int c = 0; c < 2; c++) begin
      #1; model_eval(); checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL reset_model c%0d: got %h exp %h", c, obs_vec, exp_vec); end
      checks++;
      if (disp_ready !== 1'b0 || iss_valid !== 1'b0 || iss_opcode !== '0) begin
        errors++; $display("FAIL reset_outputs: got dr=%b iv=%b op=%h exp 0 0 00", disp_ready, iss_valid, iss_opcode);
      end
      advance();
    end
    sync_rst_n = 1'b1; idle();
    #1; model_eval(); checks++;
    if (disp_ready !== 1'b1 || iss_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: got dr=%b iv=%b exp 1 0", disp_ready, iss_valid);
    end
    advance();
  endtask

  task automatic test_in_order();
    clear_q(); iss_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      idle();
      if (c < 3) set_disp(OW'(c + 1), 1, 2, 2'b11, 2'b11);
      #1; model_eval(); checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL inorder_model c%0d: got %h exp %h", c, obs_vec, exp_vec); end
      checks++;
      if (iss_valid !== (c >= 1 && c <= 3) || (iss_valid && iss_opcode !== OW'(c))) begin
        errors++; $display("FAIL inorder c%0d: got iv=%b op=%h exp iv=%b op=%h", c, iss_valid, iss_opcode, (c >= 1 && c <= 3), c);
      end
      advance();
    end
  endtask

  task automatic test_wakeup_order();
    logic [4:0] ev;
    logic [OW-1:0] eop [5];
    ev = 5'b10100;
    eop = '{7'h0, 7'h0, 7'h0B, 7'h0, 7'h0A};
    clear_q(); iss_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c == 0) set_disp(7'h0A, 5, 0, 2'b01, 2'b00);
      if (c == 1) set_disp(7'h0B, 3, 0, 2'b01, 2'b01);
      if (c == 3) begin wake_valid[0] = 1'b1; wake_addr[0] = 7'd5; end
      #1; model_eval(); checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL wake_model c%0d: got %h exp %h", c, obs_vec, exp_vec); end
      checks++;
      if (c < 5) begin
        if (iss_valid !== ev[c] || (ev[c] && iss_opcode !== eop[c])) begin
          errors++; $display("FAIL wake_order c%0d: got iv=%b op=%h exp iv=%b op=%h", c, iss_valid, iss_opcode, ev[c], eop[c]);
        end
      end else if (iss_valid !== 1'b0) begin
        errors++; $display("FAIL wake_after: got iv=%b exp 0", iss_valid);
      end
      advance();
    end
  endtask

  task automatic test_full();
    clear_q(); iss_ready = 1'b0;
    for (int i = 0; i < ENT; i++) begin
      idle(); set_disp(OW'(8'h20 + i), 0, 0, 2'b00, 2'b00);
      #1; model_eval(); checks++;
      if (obs_vec !== exp_vec || disp_ready !== 1'b1) begin
        errors++; $display("FAIL fill i%0d: got %h exp %h", i, obs_vec, exp_vec);
      end
      advance();
    end
    // Full: dispatch refused even though an issue happens this cycle.
    idle(); iss_ready = 1'b1; set_disp(7'h7E, 0, 0, 2'b00, 2'b00);
    #1; model_eval(); checks++;
    if (disp_ready !== 1'b0 || iss_valid !== 1'b1 || iss_opcode !== 7'h20) begin
      errors++; $display("FAIL full: got dr=%b iv=%b op=%h exp 0 1 20", disp_ready, iss_valid, iss_opcode);
    end
    advance();
    // Pop and dispatch together: occupancy holds, new entry is youngest.
    idle(); iss_ready = 1'b1; set_disp(7'h7F, 0, 0, 2'b00, 2'b00);
    #1; model_eval(); checks++;
    if (disp_ready !== 1'b1 || iss_opcode !== 7'h21 || obs_vec !== exp_vec) begin
      errors++; $display("FAIL pop_push: got dr=%b op=%h exp 1 21", disp_ready, iss_opcode);
    end
    advance();
    idle();
    for (int k = 0; k < ENT; k++) begin
      #1; model_eval(); checks++;
      if (k < ENT - 1) begin
        if (iss_valid !== 1'b1 || iss_opcode !== ((k < ENT - 2) ? OW'(8'h22 + k) : 7'h7F)) begin
          errors++; $display("FAIL drain k%0d: got iv=%b op=%h", k, iss_valid, iss_opcode);
        end
      end else if (iss_valid !== 1'b0) begin
        errors++; $display("FAIL drain_empty: got iv=%b exp 0", iss_valid);
      end
      advance();
    end
  endtask

  task automatic test_bypass();
    clear_q(); iss_ready = 1'b1;
    set_disp(7'h44, 9, 0, 2'b01, 2'b00);
    wake_valid = 2'b10; wake_addr[1] = 7'd9;
    #1; model_eval(); checks++;
    if (obs_vec !== exp_vec) begin errors++; $display("FAIL bypass_disp: got %h exp %h", obs_vec, exp_vec); end
    advance(); idle();
    #1; model_eval(); checks++;
    if (iss_valid !== 1'b1 || iss_opcode !== 7'h44) begin
      errors++; $display("FAIL bypass: got iv=%b op=%h exp 1 44", iss_valid, iss_opcode);
    end
    advance();
  endtask

  task automatic test_flush();
    clear_q(); iss_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin idle(); set_disp(OW'(8'h50 + i), 0, 0, 2'b00, 2'b00); #1; advance(); end
    idle(); flush = 1'b1; iss_ready = 1'b1; set_disp(7'h5F, 0, 0, 2'b00, 2'b00);
    #1; model_eval(); checks++;
    if (disp_ready !== 1'b0 || iss_valid !== 1'b1 || iss_opcode !== 7'h50) begin
      errors++; $display("FAIL flush_cycle: got dr=%b iv=%b op=%h exp 0 1 50", disp_ready, iss_valid, iss_opcode);
    end
    advance(); idle();
    #1; model_eval(); checks++;
    if (iss_valid !== 1'b0 || disp_ready !== 1'b1 || obs_vec !== exp_vec) begin
      errors++; $display("FAIL flush_after: got iv=%b dr=%b exp 0 1", iss_valid, disp_ready);
    end
    advance();
  endtask

  task automatic test_clk_en();
    clear_q(); iss_ready = 1'b0;
    set_disp(7'h31, 20, 0, 2'b01, 2'b00); #1; advance();
    idle(); set_disp(7'h32, 0, 0, 2'b00, 2'b00); #1; advance();
    for (int c = 0; c < 3; c++) begin
      idle(); clk_en = 1'b0; iss_ready = 1'b1; flush = 1'b0;
      set_disp(7'h33, 0, 0, 2'b00, 2'b00); wake_valid[0] = 1'b1; wake_addr[0] = 7'd20;
      #1; model_eval(); checks++;
      if (disp_ready !== 1'b0 || iss_valid !== 1'b0 || obs_vec !== exp_vec) begin
        errors++; $display("FAIL clk_en_off c%0d: got dr=%b iv=%b exp 0 0", c, disp_ready, iss_valid);
      end
      advance();
    end
    for (int c = 0; c < 5; c++) begin
      idle(); iss_ready = 1'b1;
      if (c == 2) begin wake_valid[1] = 1'b1; wake_addr[1] = 7'd20; end
      #1; model_eval(); checks++;
      if (iss_valid !== (c == 0 || c == 3) ||
          (c == 0 && iss_opcode !== 7'h32) || (c == 3 && iss_opcode !== 7'h31)) begin
        errors++; $display("FAIL clk_en_resume c%0d: got iv=%b op=%h", c, iss_valid, iss_opcode);
      end
      advance();
    end
  endtask

  task automatic test_random();
    clear_q();
    for (int c = 0; c < 1500; c++) begin
      idle();
      clk_en     = ($urandom_range(0, 9) != 0);
      flush      = ($urandom_range(0, 59) == 0);
      disp_valid = $urandom_range(0, 1);
      disp_opcode = OW'($urandom); disp_dest_addr = AW'($urandom);
      disp_src_addr[0] = AW'($urandom_range(0, 15)); disp_src_addr[1] = AW'($urandom_range(0, 15));
      disp_src_used = 2'($urandom); disp_src_rdy = 2'($urandom_range(0, 3) & $urandom_range(0, 3));
      for (int p = 0; p < WP; p++) begin
        wake_valid[p] = ($urandom_range(0, 3) == 0);
        wake_addr[p]  = AW'($urandom_range(0, 15));
      end
      iss_ready = ((c / 150) % 2 == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0) sync_rst_n = 1'b0;
      #1; model_eval(); checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL random c%0d: got %h exp %h", c, obs_vec, exp_vec); end
      advance();
      sync_rst_n = 1'b1;
    end
  endtask

  initial begin
    sync_rst_n = 1'b0; iss_ready = 1'b0; idle();
    @(negedge clk);
    test_reset();
    test_in_order();
    test_wakeup_order();
    test_full();
    test_bypass();
    test_flush();
    test_clk_en();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
